// File: rtl/seq_reorder_pkg.sv
// Packet field layout and slot storage type for the sequence reorder buffer.
// Offsets describe the default network configuration; packet_size() covers the others.
package seq_reorder_pkg;
    localparam int NETWORK_SIZE_DEF  = 256;
    localparam int PAYLOAD_WIDTH_DEF = 22;
    localparam int SEQ_WIDTH_DEF     = 4;
    localparam int TYPE_WIDTH_DEF    = 2;
    localparam int NODE_WIDTH_DEF    = $clog2(NETWORK_SIZE_DEF);

    // Packet is {type, dest, source, seq, payload}, payload at the LSBs.
    localparam int SEQ_START    = PAYLOAD_WIDTH_DEF;
    localparam int SOURCE_START = SEQ_START + SEQ_WIDTH_DEF;
    localparam int DEST_START   = SOURCE_START + NODE_WIDTH_DEF;
    localparam int TYPE_START   = DEST_START + NODE_WIDTH_DEF;
    localparam int PACKET_SIZE  = TYPE_START + TYPE_WIDTH_DEF;

    typedef struct packed {
        logic                   vld;
        logic [PACKET_SIZE-1:0] pkt;
    } slot_t;

    function automatic int packet_size(input int network_size, input int payload_width,
                                       input int seq_width, input int type_width);
        return type_width + 2 * $clog2(network_size) + seq_width + payload_width;
    endfunction
endpackage

// File: rtl/seq_slot_select.sv
// Lowest-index priority encoder: reports whether any request bit is set and
// the index of the lowest one.
module seq_slot_select #(
    parameter  int N     = 32,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    output logic             found,
    output logic [IDX_W-1:0] idx
);
    always_comb begin
        found = |req;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = IDX_W'(i);
        end
    end
endmodule

// File: rtl/seq_reorder_buffer.sv
// Reorders NI spike packets into sequence-number order for the MUL stage.
// SEQ_REORDER_STALE_DROP_EN: discard packets behind cur_seq instead of storing them.
module seq_reorder_buffer
    import seq_reorder_pkg::*;
#(
    parameter  int NETWORK_SIZE  = NETWORK_SIZE_DEF,
    parameter  int PAYLOAD_WIDTH = PAYLOAD_WIDTH_DEF,
    parameter  int SEQ_WIDTH     = SEQ_WIDTH_DEF,
    parameter  int TYPE_WIDTH    = TYPE_WIDTH_DEF,
    parameter  int DEPTH         = 32,
    parameter  int CNT_WIDTH     = 8,
    localparam int PKT_W = packet_size(NETWORK_SIZE, PAYLOAD_WIDTH, SEQ_WIDTH, TYPE_WIDTH),
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [PKT_W-1:0]     in_packet,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [PKT_W-1:0]     out_packet,
    input  logic                 out_ready,
    input  logic [CNT_WIDTH-1:0] cfg_expected,
    output logic [SEQ_WIDTH-1:0] cur_seq,
    output logic [OCC_W-1:0]     occupancy,
    output logic                 drop_stale
);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int SEQ_LO = PAYLOAD_WIDTH;

    logic [DEPTH-1:0]     slot_vld;
    logic [PKT_W-1:0]     slot_pkt [DEPTH];
    logic [DEPTH-1:0]     match;
    logic                 hit, free_found;
    logic [IDX_W-1:0]     hit_idx, free_idx;
    logic [SEQ_WIDTH-1:0] in_seq;
    logic                 in_match, bypass_sel, bypass_taken, stale;
    logic                 wr_en, rel, rel_buf, advance;
    logic [CNT_WIDTH-1:0] release_cnt, cnt_target;
    logic [CNT_WIDTH:0]   cnt_inc;

    for (genvar g = 0; g < DEPTH; g++) begin : g_match
        assign match[g] = slot_vld[g] && (slot_pkt[g][SEQ_LO +: SEQ_WIDTH] == cur_seq);
    end

    seq_slot_select #(.N(DEPTH)) u_match_sel (.req(match),     .found(hit),        .idx(hit_idx));
    seq_slot_select #(.N(DEPTH)) u_free_sel  (.req(~slot_vld), .found(free_found), .idx(free_idx));

    assign in_seq = in_packet[SEQ_LO +: SEQ_WIDTH];

`ifdef SEQ_REORDER_STALE_DROP_EN
    logic [SEQ_WIDTH-1:0] seq_dist;
    // Modular distance ahead of cur_seq; the upper half of the ring counts as behind.
    assign seq_dist = in_seq - cur_seq;
    assign stale    = in_valid & seq_dist[SEQ_WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_stale <= 1'b0;
        else        drop_stale <= stale;
    end
`else
    assign stale      = 1'b0;
    assign drop_stale = 1'b0;
`endif

    // Buffered matches win over a matching input so older copies drain first.
    assign in_match     = in_valid && (in_seq == cur_seq);
    assign bypass_sel   = in_match & ~hit;
    assign out_valid    = hit | bypass_sel;
    assign out_packet   = hit ? slot_pkt[hit_idx] : in_packet;
    assign bypass_taken = bypass_sel & out_ready;
    assign in_ready     = bypass_taken | free_found | stale;

    assign wr_en      = in_valid & free_found & ~bypass_taken & ~stale;
    assign rel        = out_valid & out_ready;
    assign rel_buf    = hit & out_ready;
    assign cnt_target = (cfg_expected == '0) ? CNT_WIDTH'(1) : cfg_expected;
    assign cnt_inc    = {1'b0, release_cnt} + (CNT_WIDTH + 1)'(1);
    assign advance    = rel && (cnt_inc >= {1'b0, cnt_target});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_vld    <= '0;
            cur_seq     <= '0;
            release_cnt <= '0;
            occupancy   <= '0;
        end else begin
            // Write and release never target the same slot: one is free, the other valid.
            if (wr_en)   slot_vld[free_idx] <= 1'b1;
            if (rel_buf) slot_vld[hit_idx]  <= 1'b0;
            if (advance) begin
                cur_seq     <= cur_seq + SEQ_WIDTH'(1);
                release_cnt <= '0;
            end else if (rel) begin
                release_cnt <= cnt_inc[CNT_WIDTH-1:0];
            end
            occupancy <= occupancy + OCC_W'(wr_en) - OCC_W'(rel_buf);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) slot_pkt[free_idx] <= in_packet;
    end
endmodule
